// File: rtl/video_timing_gen.sv
// Raster timing generator: cx/cy counters, de/hsync/vsync, frame_start and frame_count, all registered and aligned.
// Optional image_change pulse every FRAMES_PER_IMAGE frames when VTG_IMAGE_CHANGE_EN is defined.
module video_timing_gen #(
  parameter int FRAME_WIDTH      = 1344,
  parameter int FRAME_HEIGHT     = 806,
  parameter int SCREEN_WIDTH     = 1024,
  parameter int SCREEN_HEIGHT    = 768,
  parameter int H_FRONT_PORCH    = 24,
  parameter int H_SYNC_WIDTH     = 136,
  parameter int V_FRONT_PORCH    = 3,
  parameter int V_SYNC_WIDTH     = 6,
  parameter int BIT_WIDTH        = 12,
  parameter int BIT_HEIGHT       = 11,
  parameter int FRAMES_PER_IMAGE = 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  enable,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start,
  output logic                  image_change,
  output logic [31:0]           frame_count,
  output logic                  running
);

  localparam int HS_BEG = SCREEN_WIDTH + H_FRONT_PORCH;
  localparam int HS_END = HS_BEG + H_SYNC_WIDTH;
  localparam int VS_BEG = SCREEN_HEIGHT + V_FRONT_PORCH;
  localparam int VS_END = VS_BEG + V_SYNC_WIDTH;

  localparam logic [BIT_WIDTH-1:0]  X_LAST = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT-1:0] Y_LAST = BIT_HEIGHT'(FRAME_HEIGHT - 1);
  localparam logic [BIT_WIDTH-1:0]  X_ONE  = 1;
  localparam logic [BIT_HEIGHT-1:0] Y_ONE  = 1;

  generate
    if (longint'(FRAME_WIDTH) > (longint'(1) << BIT_WIDTH)) begin : g_bad_fw
      $error("FRAME_WIDTH does not fit in BIT_WIDTH");
    end
    if (longint'(FRAME_HEIGHT) > (longint'(1) << BIT_HEIGHT)) begin : g_bad_fh
      $error("FRAME_HEIGHT does not fit in BIT_HEIGHT");
    end
    if (HS_END > FRAME_WIDTH || VS_END > FRAME_HEIGHT) begin : g_bad_sync
      $error("sync window extends beyond the frame");
    end
    if (FRAMES_PER_IMAGE < 1) begin : g_bad_fpi
      $error("FRAMES_PER_IMAGE must be at least 1");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic                  end_of_frame;
  logic [BIT_WIDTH-1:0]  x_nxt;
  logic [BIT_HEIGHT-1:0] y_nxt;
  logic                  de_nxt, hs_nxt, vs_nxt, fs_nxt;

  assign end_of_frame = (cx == X_LAST) && (cy == Y_LAST);
  assign running      = (state == RUN);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  // Leaving RUN is only allowed on the last pixel so frames are never truncated.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (end_of_frame && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Qualifiers are derived from the next position so they register alongside cx/cy.
  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (state == RUN && !end_of_frame) begin
      if (cx == X_LAST) begin
        y_nxt = cy + Y_ONE;
      end else begin
        x_nxt = cx + X_ONE;
        y_nxt = cy;
      end
    end
    de_nxt = (state_nxt == RUN) && (32'(x_nxt) < SCREEN_WIDTH) && (32'(y_nxt) < SCREEN_HEIGHT);
    hs_nxt = !((state_nxt == RUN) && (32'(x_nxt) >= HS_BEG) && (32'(x_nxt) < HS_END));
    vs_nxt = !((state_nxt == RUN) && (32'(y_nxt) >= VS_BEG) && (32'(y_nxt) < VS_END));
    fs_nxt = (state_nxt == RUN) && (x_nxt == '0) && (y_nxt == '0);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cx          <= '0;
      cy          <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      cx          <= x_nxt;
      cy          <= y_nxt;
      de          <= de_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt) frame_count <= frame_count + 32'd1;
    end
  end

`ifdef VTG_IMAGE_CHANGE_EN
  localparam int IC_W = $clog2(FRAMES_PER_IMAGE + 1);
  localparam logic [IC_W-1:0] IC_ONE = 1;
  logic [IC_W-1:0] img_cnt;

  // The frame_start that completes a group fires image_change and restarts the group.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      img_cnt      <= '0;
      image_change <= 1'b0;
    end else begin
      image_change <= 1'b0;
      if (fs_nxt) begin
        if (32'(img_cnt) == FRAMES_PER_IMAGE - 1) begin
          img_cnt      <= '0;
          image_change <= 1'b1;
        end else begin
          img_cnt <= img_cnt + IC_ONE;
        end
      end
    end
  end
`else
  assign image_change = 1'b0;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- FRAME_WIDTH, 1344, total pixel clocks per line.
- FRAME_HEIGHT, 806, total lines per frame.
- SCREEN_WIDTH, 1024, active pixels per line.
- SCREEN_HEIGHT, 768, active lines per frame.
- H_FRONT_PORCH, 24, pixel clocks from end of active video to hsync start.
- H_SYNC_WIDTH, 136, hsync length in pixel clocks.
- V_FRONT_PORCH, 3, lines from end of active video to vsync start.
- V_SYNC_WIDTH, 6, vsync length in lines.
- BIT_WIDTH, 12, cx width.
- BIT_HEIGHT, 11, cy width.
- FRAMES_PER_IMAGE, 1, frames per image_change pulse (minimum 1).
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- s_axi_aclk, in, 1, pixel clock, the single clock.
- s_axi_aresetn, in, 1, asynchronous active-low reset.
- enable, in, 1, level request to run the raster.
- cx, out, BIT_WIDTH, current pixel column.
- cy, out, BIT_HEIGHT, current line.
- de, out, 1, active-video qualifier.
- hsync, out, 1, horizontal sync, active-low.
- vsync, out, 1, vertical sync, active-low.
- frame_start, out, 1, one-cycle pulse at pixel (0,0).
- image_change, out, 1, one-cycle pulse requesting the next image.
- frame_count, out, 32, count of started frames.
- running, out, 1, high while the state is RUN.

Function
REQ-003 The block SHALL implement a state machine with states IDLE and RUN.
- IDLE to RUN on the first rising edge with enable=1.
- RUN to IDLE only at end of frame, cx=FRAME_WIDTH-1 and cy=FRAME_HEIGHT-1, when enable=0.
REQ-004 In RUN, cx SHALL increment by 1 each cycle and wrap from FRAME_WIDTH-1 to 0. cy SHALL increment on each cx wrap and wrap from FRAME_HEIGHT-1 to 0.
REQ-005 In IDLE, cx and cy SHALL hold 0. de, frame_start and image_change SHALL be 0. hsync and vsync SHALL be 1.
REQ-006 All outputs SHALL be registered and mutually aligned: every qualifier describes the cx/cy value presented in the same cycle.
REQ-007 de SHALL be 1 iff the state is RUN, cx<SCREEN_WIDTH and cy<SCREEN_HEIGHT.
REQ-008 hsync SHALL be 0 iff cx is in [SCREEN_WIDTH+H_FRONT_PORCH, SCREEN_WIDTH+H_FRONT_PORCH+H_SYNC_WIDTH). For defaults this is 1048..1183.
REQ-009 vsync SHALL be 0 iff cy is in [SCREEN_HEIGHT+V_FRONT_PORCH, SCREEN_HEIGHT+V_FRONT_PORCH+V_SYNC_WIDTH). For defaults this is 771..776, for whole lines.
REQ-010 frame_start SHALL pulse for exactly one cycle whenever RUN presents cx=0 and cy=0, including the first cycle after leaving IDLE.
REQ-011 frame_count SHALL increment by 1, modulo 2^32, in the cycle frame_start is asserted. It SHALL hold while in IDLE.
REQ-012 enable deasserted mid-frame SHALL NOT truncate the frame; the frame completes and the block then enters IDLE.
REQ-013 enable reasserted on the final cycle of a frame SHALL keep the block in RUN with no idle gap.
REQ-014 Parameters SHALL satisfy FRAME_WIDTH<=2^BIT_WIDTH, FRAME_HEIGHT<=2^BIT_HEIGHT, and both sync windows inside the frame. Violations SHALL raise an elaboration-time error.

Reset
REQ-015 Asserting s_axi_aresetn=0 SHALL immediately force:
- state to IDLE;
- cx=0, cy=0, de=0, frame_start=0, image_change=0, running=0;
- hsync=1, vsync=1;
- frame_count=0, image-change counter=0.
REQ-016 Reset asserted mid-frame SHALL abandon the frame. After deassertion, a new frame SHALL start only per REQ-003.

Configuration
REQ-017 Macro VTG_IMAGE_CHANGE_EN controls the image_change feature.
- Defined: an internal counter counts frame_start pulses; image_change pulses together with the frame_start that completes each group of FRAMES_PER_IMAGE frames, and the counter then clears. With FRAMES_PER_IMAGE=1, image_change equals frame_start.
- Not defined: image_change is tied to 0 and no counter logic is present.

Verification
REQ-018 Reset, then enable=1 held -> first RUN cycle shows cx=0, cy=0, frame_start=1, frame_count=1, de=1.
REQ-019 Free run with defaults -> de high for exactly 1024x768 cycles per frame; hsync low for cx 1048..1183; vsync low for cy 771..776; frame_start period 1083264 cycles.
REQ-020 Deassert enable at cx=500, cy=100 -> raster continues to (1343,805), then IDLE with cx=0, cy=0, running=0, frame_count unchanged.
REQ-021 Assert reset at cx=700, cy=400 -> all outputs take their reset values in the same cycle; after release with enable=1, frame_count restarts at 1.
REQ-022 With VTG_IMAGE_CHANGE_EN defined and FRAMES_PER_IMAGE=3 -> image_change pulses at frames 3, 6, 9 (frame_count values), each aligned with frame_start.
REQ-023 Without VTG_IMAGE_CHANGE_EN and FRAMES_PER_IMAGE=3 -> image_change stays 0 over 10 frames; all other outputs are identical to the REQ-022 run.
